dwrr_pkt_arbiter: RTL and testbench

Deficit weighted round-robin arbiter for variable-length, multi-flit packets.
- Each requestor presents its head-packet length in flits.
- A grant is held for the whole packet. The deficit counter is debited by the packet length. A programmable per-channel quantum is credited on each visit.
- Adds stall (blk) support, sop/eop framing, channel disable (quantum 0), saturating deficit arithmetic and skipping of empty channels.
- Sits between per-channel packet queues and a shared output link.

---
 rtl/dwrr_pkt_arbiter_pkg.sv | 29 ++
 rtl/dwrr_pkt_arbiter_rr_next_finder.sv | 30 +++
 rtl/dwrr_pkt_arbiter.sv | 155 +++++++++++++++
 tb/tb_dwrr_pkt_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwrr_pkt_arbiter_pkg.sv
// Shared types and helpers for the deficit weighted round-robin packet arbiter.
package dwrr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    XFER = 2'd3
  } state_t;

  // Unsigned add clamped to the largest value representable in w bits.
  // Operands are carried at 32 bits so one helper serves any counter width;
  // the caller casts the result back down to its own width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] maxv;
    sum  = {1'b0, a} + {1'b0, b};
    maxv = (33'd1 << w) - 33'd1;
    return (sum > maxv) ? maxv[31:0] : sum[31:0];
  endfunction

  // A zero-length head packet is still one flit on the link.
  function automatic logic [31:0] len_nz(input logic [31:0] l);
    return (l == 32'd0) ? 32'd1 : l;
  endfunction

endpackage

// File: rtl/dwrr_pkt_arbiter_rr_next_finder.sv
// Combinational round-robin search: first eligible index strictly after
// start, wrapping, with start itself checked last.
module rr_next_finder
  import dwrr_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] elig,
  input  logic [CNTWID-1:0]   start,
  output logic                found,
  output logic [CNTWID-1:0]   idx
);

  // Scan from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    logic [CNTWID-1:0] j;
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      j = CNTWID'((int'(start) + k) % NUM_REQS);
      if (elig[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/dwrr_pkt_arbiter.sv
// Deficit weighted round-robin arbiter for multi-flit packets. A channel is
// credited its quantum once per visit and debited each packet's length; the
// grant is held for the whole packet and honours link stalls.
module dwrr_pkt_arbiter
  import dwrr_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int QWID     = 8,
  parameter int LWID     = 4,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS*LWID-1:0] req_lens,
  input  logic [NUM_REQS*QWID-1:0] input_quantums,
  output logic [NUM_REQS-1:0]      gnt,
  output logic [CNTWID-1:0]        gnt_idx,
  output logic                     sop,
  output logic                     eop,
  output logic                     busy
);

  state_t                          state_q, state_d;
  logic [CNTWID-1:0]               cur_q, cur_d;
  logic [NUM_REQS-1:0][QWID-1:0]   def_q, def_d;
  logic [LWID-1:0]                 cnt_q, cnt_d;
  logic [LWID-1:0]                 len_q, len_d;
  logic [NUM_REQS-1:0]             gnt_q, gnt_d;
  logic                            sop_q, sop_d;
  logic                            eop_q, eop_d;
  logic                            busy_q, busy_d;

  logic [NUM_REQS-1:0]             elig;
  logic                            found;
  logic [CNTWID-1:0]               nxt_idx;
  logic [QWID-1:0]                 quantum_cur;
  logic [QWID-1:0]                 def_cur;
  logic [LWID-1:0]                 len_cur;

  assign quantum_cur = input_quantums[cur_q*QWID +: QWID];
  assign def_cur     = def_q[cur_q];
  assign len_cur     = LWID'(len_nz(32'(req_lens[cur_q*LWID +: LWID])));

  // A channel competes only when it has a packet and a nonzero quantum.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig[i] = reqs[i] && (input_quantums[i*QWID +: QWID] != '0);
    end
  end

  rr_next_finder #(
    .NUM_REQS (NUM_REQS),
    .CNTWID   (CNTWID)
  ) u_finder (
    .elig  (elig),
    .start (cur_q),
    .found (found),
    .idx   (nxt_idx)
  );

  // Next-state, deficit bookkeeping and flit counting.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    def_d   = def_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          cur_d   = nxt_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        def_d[cur_q] = QWID'(sat_add(32'(def_cur), 32'(quantum_cur), QWID));
        state_d      = EVAL;
      end
      EVAL: begin
        if (reqs[cur_q] && (32'(len_cur) <= 32'(def_cur))) begin
          def_d[cur_q] = def_cur - QWID'(len_cur);
          cnt_d        = len_cur;
          len_d        = len_cur;
          state_d      = XFER;
        end else if (found) begin
          cur_d   = nxt_idx;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!blk) begin
          cnt_d = cnt_q - LWID'(1);
          if (cnt_q == LWID'(1)) begin
            state_d = EVAL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An empty queue forfeits its deficit, except the channel mid-packet.
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!reqs[i] && !((state_q == XFER) && (cur_q == CNTWID'(i)))) begin
        def_d[i] = '0;
      end
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    gnt_d = '0;
    if (state_d == XFER) begin
      gnt_d[cur_d] = 1'b1;
    end
    sop_d  = (state_d == XFER) && (cnt_d == len_d);
    eop_d  = (state_d == XFER) && (cnt_d == LWID'(1));
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      def_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      def_q   <= def_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = cur_q;
  assign sop     = sop_q;
  assign eop     = eop_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dwrr_pkt_arbiter.sv
// Bench for dwrr_pkt_arbiter: directed scenarios with hand-derived timing plus
// a long randomized run compared every cycle against a behavioural model.
module tb_dwrr_pkt_arbiter;
  import dwrr_pkg::*;

  localparam int N    = 4;
  localparam int QW   = 8;
  localparam int LW   = 4;
  localparam int CW   = 2;
  localparam int QMAX = (1 << QW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            blk = 1'b0;
  logic [N-1:0]    reqs = '0;
  logic [N*LW-1:0] req_lens = '0;
  logic [N*QW-1:0] input_quantums = '0;
  logic [N-1:0]    gnt;
  logic [CW-1:0]   gnt_idx;
  logic            sop, eop, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dwrr_pkt_arbiter #(.NUM_REQS(N), .QWID(QW), .LWID(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .blk            (blk),
    .reqs           (reqs),
    .req_lens       (req_lens),
    .input_quantums (input_quantums),
    .gnt            (gnt),
    .gnt_idx        (gnt_idx),
    .sop            (sop),
    .eop            (eop),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 credit, 2 decide, 3 sending
  int m_ph, m_cur, m_rem, m_len;
  int m_def[N];

  function automatic int q_of(int i);
    return int'(input_quantums[i*QW +: QW]);
  endfunction
  function automatic int l_of(int i);
    return int'(req_lens[i*LW +: LW]);
  endfunction
  function automatic bit can_go(int i);
    return reqs[i] && (q_of(i) != 0);
  endfunction
  function automatic int search(int s);
    for (int k = 1; k <= N; k++) begin
      if (can_go((s + k) % N)) return (s + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int nph, ncur, nrem, nlen, nx, len, credit;
    int nd[N];
    if (!rst) begin
      m_ph <= 0; m_cur <= 0; m_rem <= 0; m_len <= 0;
      for (int i = 0; i < N; i++) m_def[i] <= 0;
    end else begin
      nph = m_ph; ncur = m_cur; nrem = m_rem; nlen = m_len;
      for (int i = 0; i < N; i++) nd[i] = m_def[i];
      nx = search(m_cur);
      if (m_ph == 0) begin
        if (nx >= 0) begin ncur = nx; nph = 1; end
      end else if (m_ph == 1) begin
        credit = m_def[m_cur] + q_of(m_cur);
        nd[m_cur] = (credit > QMAX) ? QMAX : credit;
        nph = 2;
      end else if (m_ph == 2) begin
        len = (l_of(m_cur) == 0) ? 1 : l_of(m_cur);
        if (reqs[m_cur] && len <= m_def[m_cur]) begin
          nd[m_cur] = m_def[m_cur] - len; nrem = len; nlen = len; nph = 3;
        end else if (nx >= 0) begin
          ncur = nx; nph = 1;
        end else begin
          nph = 0;
        end
      end else if (!blk) begin
        if (m_rem == 1) nph = 2;
        nrem = m_rem - 1;
      end
      for (int i = 0; i < N; i++) begin
        if (!reqs[i] && !(m_ph == 3 && m_cur == i)) nd[i] = 0;
      end
      m_ph <= nph; m_cur <= ncur; m_rem <= nrem; m_len <= nlen;
      for (int i = 0; i < N; i++) m_def[i] <= nd[i];
    end
  end

  // Every-cycle comparison of all outputs and deficits against the model.
  always @(negedge clk) begin
    logic [N-1:0]    eg;
    logic [N*QW-1:0] ed;
    if (rst) begin
      eg = (m_ph == 3) ? (N'(1) << m_cur) : '0;
      check("outputs", {gnt, gnt_idx, sop, eop, busy},
            {eg, CW'(m_cur), (m_ph == 3) && (m_rem == m_len), (m_ph == 3) && (m_rem == 1), m_ph != 0});
      for (int i = 0; i < N; i++) ed[i*QW +: QW] = QW'(m_def[i]);
      check("deficits", dut.def_q, ed);
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst = 1'b0; blk = 1'b0; reqs = '0; req_lens = '0; input_quantums = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_sop(input string name);
    int n;
    n = 0;
    while (!sop && n < 60) begin @(negedge clk); n++; end
    check(name, sop, 1'b1);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int t0, c0, c1, last, maxgap, n, first_eop, flits, gcnt, rounds, busy_cnt, g2, r;
    int sops[$];
    int eops[$];
    int ecnt[N];
    state_t prev;

    // ---- reset state ----
    do_reset();
    check("reset_busy", busy, 1'b0);
    check("reset_gnt", gnt, '0);
    check("reset_def", dut.def_q, '0);
    check("reset_idle", dut.state_q == IDLE, 1'b1);

    // ---- single channel, q=8, len=4: exact timing ----
    input_quantums[0 +: QW] = 8; req_lens[0 +: LW] = 4; reqs = 4'b0001; t0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (sop) sops.push_back(cyc - t0);
      if (eop) eops.push_back(cyc - t0);
      if (k == 3) check("s1_gnt_at3", gnt, 4'b0001);
      if (k == 7) check("s1_eval_gap", gnt, 4'b0000);
    end
    check("s1_sop0", qget(sops, 0), 3);
    check("s1_eop0", qget(eops, 0), 6);
    check("s1_sop1", qget(sops, 1), 8);
    check("s1_eop1", qget(eops, 1), 11);
    check("s1_sop2", qget(sops, 2), 15);

    // ---- q 8 vs 16, len 8: two ch1 packets per ch0 packet ----
    do_reset();
    input_quantums[0 +: QW] = 8; input_quantums[QW +: QW] = 16;
    req_lens[0 +: LW] = 8; req_lens[LW +: LW] = 8; reqs = 4'b0011;
    c1 = 0; last = -1; maxgap = 0; rounds = 0; c0 = 0;
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      if (eop) begin
        if (gnt_idx == 0) begin
          if (c0 > 0) begin check("s2_ch1_per_round", c1, 2); rounds++; end
          c0++; c1 = 0;
        end else c1++;
      end
      if (gnt != 0) begin
        if (last >= 0 && cyc - last - 1 > maxgap) maxgap = cyc - last - 1;
        last = cyc;
      end
    end
    check("s2_rounds_seen", rounds >= 5, 1'b1);
    check("s2_max_gap", maxgap, 3);

    // ---- disabled channel never granted; all disabled stays idle ----
    do_reset();
    input_quantums = {8'd8, 8'd0, 8'd8, 8'd8};
    req_lens = {4'd3, 4'd2, 4'd5, 4'd7}; reqs = 4'b1111;
    g2 = 0;
    for (int i = 0; i < N; i++) ecnt[i] = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (gnt[2]) g2++;
      if (eop) ecnt[gnt_idx]++;
    end
    check("s3_gnt2_never", g2, 0);
    check("s3_ch0_served", ecnt[0] > 0, 1'b1);
    check("s3_ch3_served", ecnt[3] > 0, 1'b1);
    do_reset();
    reqs = 4'b1111; req_lens = {4'd1, 4'd1, 4'd1, 4'd1};
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (busy) busy_cnt++; end
    check("s3_all_zero_idle", busy_cnt, 0);

    // ---- 3-cycle stall mid-packet, len 5 ----
    do_reset();
    input_quantums[0 +: QW] = 8; req_lens[0 +: LW] = 5; reqs = 4'b0001;
    wait_sop("s4_sop_seen");
    first_eop = -1; flits = 0; gcnt = 0;
    for (r = 0; r < 10; r++) begin
      if (r > 0) @(negedge clk);
      if (gnt[0]) gcnt++;
      if (gnt[0] && eop && first_eop < 0) first_eop = r;
      blk = (r >= 2 && r <= 4);
      if (gnt[0] && !blk) flits++;
    end
    blk = 1'b0;
    check("s4_eop_delay", first_eop, 7);
    check("s4_flits", flits, 5);
    check("s4_gnt_held", gcnt, 8);

    // ---- saturation: q0=255 with len 7 leaves 3, next credit clamps ----
    do_reset();
    input_quantums[0 +: QW] = 255; input_quantums[QW +: QW] = 8;
    req_lens[0 +: LW] = 7; req_lens[LW +: LW] = 15; reqs = 4'b0011;
    n = 0; prev = IDLE;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (dut.state_q == EVAL && prev == LOAD && gnt_idx == 0) begin
        check("s5_credit_clamp", dut.def_q[0], 255);
        n++;
      end
      prev = dut.state_q;
    end
    check("s5_ch0_credits", n, 2);

    // ---- empty channel loses its deficit ----
    do_reset();
    input_quantums[0 +: QW] = 8; req_lens[0 +: LW] = 15; reqs = 4'b0001;
    n = 0;
    while (dut.state_q != EVAL && n < 20) begin @(negedge clk); n++; end
    check("s6_def_before", dut.def_q[0], 8);
    reqs = 4'b0000;
    @(negedge clk);
    check("s6_def_cleared", dut.def_q[0], 0);
    check("s6_back_idle", busy, 1'b0);

    // ---- asynchronous reset in the second flit of a 4-flit packet ----
    do_reset();
    input_quantums[0 +: QW] = 8; req_lens[0 +: LW] = 4; reqs = 4'b0001;
    wait_sop("s7_sop_seen");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("s7_gnt_cleared", {gnt, sop, eop, busy}, '0);
    @(negedge clk);
    check("s7_state_idle", dut.state_q == IDLE, 1'b1);
    check("s7_def_zero", dut.def_q, '0);
    rst = 1'b1; t0 = cyc;
    wait_sop("s7_rearb_sop");
    check("s7_rearb_latency", cyc - t0, 3);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < N; i++) begin
      input_quantums[i*QW +: QW] = QW'($urandom_range(0, 40));
      req_lens[i*LW +: LW] = LW'($urandom_range(0, 15));
    end
    for (int k = 0; k < 3000; k++) begin
      int ch, pick;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          reqs[i] = ~reqs[i];
          req_lens[i*LW +: LW] = LW'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 63) == 0) begin
        ch = int'($urandom_range(0, N - 1));
        case ($urandom_range(0, 3))
          0: pick = 0;
          1: pick = 255;
          2: pick = int'($urandom_range(1, 8));
          default: pick = int'($urandom_range(0, 255));
        endcase
        input_quantums[ch*QW +: QW] = QW'(pick);
      end
      blk = ($urandom_range(0, 3) == 0);
    end
    blk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
